mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 41 ++++
 rtl/mem_access_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//   Signal bundle between the core load/store unit, the access controller
//   and the data-memory bus.
//
//   Core side : mem_read, mem_write, fn3, addr, wdata  -> controller
//               stall, rdata, err                      <- controller
//   Bus side  : bus_req, bus_we, bus_addr, bus_be,
//               bus_wdata                              <- controller
//               bus_ready, bus_rdata                   -> controller
//
//   master : controller view (drives stall/rdata/err and the bus request)
//   slave  : environment view (core requests plus memory response)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  fn3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   modport master (
      input  mem_read, mem_write, fn3, addr, wdata, bus_ready, bus_rdata,
      output stall, rdata, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
   );

   modport slave (
      output mem_read, mem_write, fn3, addr, wdata, bus_ready, bus_rdata,
      input  stall, rdata, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Turns RISC-V byte/half/word load-store requests into single-beat
//   data-memory bus accesses. Holds the core with stall while an access is
//   outstanding, aborts after TIMEOUT cycles without bus_ready, and flags
//   illegal or misaligned requests with a one-cycle err pulse.
//
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous, active-high
//     io    - mem_access_ctrl_if.master (core request/response + memory bus)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   mem_access_ctrl_if.master io
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic        to_flag, to_flag_nx;
   logic [31:0] rdata_q;
   logic        req, illegal, misalign, accept, capture, stall, err;

   // request captured at acceptance
   logic        we_p0;
   logic [2:0]  fn3_p0;
   logic [31:0] addr_p0;
   logic [31:0] wdata_p0;

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // fn3[2] selects zero extension (BU/HU)
   function automatic logic [31:0] load_extract(input logic [2:0] f, input logic [1:0] off,
                                                input logic [31:0] word);
      logic [31:0] b_sh, h_sh;
      b_sh = word >> {off, 3'b000};
      h_sh = word >> {off[1], 4'b0000};
      case (f[1:0])
         2'b00:   return {{24{b_sh[7] & ~f[2]}}, b_sh[7:0]};
         2'b01:   return {{16{h_sh[15] & ~f[2]}}, h_sh[15:0]};
         default: return word;
      endcase
   endfunction

   always_comb begin
      req      = io.mem_read | io.mem_write;
      illegal  = (io.mem_read & io.mem_write)
               | (io.mem_write & (io.fn3[2] | (io.fn3[1:0] == 2'b11)))
               | (io.mem_read & ((io.fn3[1:0] == 2'b11) | (io.fn3[2:1] == 2'b11)));
      misalign = ((io.fn3[1:0] == 2'b01) & io.addr[0])
               | ((io.fn3[1:0] == 2'b10) & (io.addr[1:0] != 2'b00));
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      to_flag_nx = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      stall      = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (illegal | misalign) begin
                  err = 1'b1;
               end else begin
                  accept   = 1'b1;
                  stall    = 1'b1;
                  state_nx = ACCESS;
               end
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (io.bus_ready) begin
               capture  = ~we_p0;
               cnt_nx   = 8'd0;
               state_nx = DONE;
            end else begin
               cnt_nx = cnt + 8'd1;
               if (cnt + 8'd1 == 8'(TIMEOUT)) begin
                  to_flag_nx = 1'b1;
                  state_nx   = DONE;
               end
            end
         end
         DONE: begin
            // timeout err is reported here, after bus_req has dropped
            err      = to_flag;
            cnt_nx   = 8'd0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // control state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         to_flag <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         to_flag <= to_flag_nx;
         if (capture) rdata_q <= load_extract(fn3_p0, addr_p0[1:0], io.bus_rdata);
      end
   end

   // request latch
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p0    <= io.mem_write;
         fn3_p0   <= io.fn3;
         addr_p0  <= io.addr;
         wdata_p0 <= io.wdata;
      end
   end

   assign io.stall     = stall;
   assign io.err       = err;
   assign io.rdata     = rdata_q;
   assign io.bus_req   = (state == ACCESS);
   assign io.bus_we    = (state == ACCESS) & we_p0;
   assign io.bus_addr  = {addr_p0[31:2], 2'b00};
   assign io.bus_be    = (state == ACCESS) ? lane_be(fn3_p0[1:0], addr_p0[1:0]) : 4'b0000;
   assign io.bus_wdata = lane_wdata(fn3_p0[1:0], wdata_p0);

endmodule
